// File: rtl/pcie_tx_pkg.sv
// Shared types and helpers for the PCIe TX credit-aware VC scheduler.
//   vc_idx_w()     : index width for a VC count (at least 1 bit)
//   sched_state_e  : output-register FSM states
//   cred_sat_add() : credit return with saturation at the counter's all-ones value
package pcie_tx_pkg;

  function automatic int unsigned vc_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_e;

  // base + ret clamped to (2**w)-1; base is already net of consumption, so it never underflows
  function automatic logic [31:0] cred_sat_add(input logic [31:0] base,
                                               input logic [31:0] ret,
                                               input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, base} + {1'b0, ret};
    max = (33'(1) << w) - 33'(1);
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/pcie_fc_credit_ctr.sv
// Per-VC flow-control credit counter.
//   consume_i/dcred_need_i : one header credit plus the head TLP's data credits are spent on grant
//   upd_i/upd_hdr_i/upd_data_i : credits returned by the link partner
//   eligible_c_o : combinational; VC has a TLP and enough registered credits for it
module pcie_fc_credit_ctr
  import pcie_tx_pkg::*;
#(
  parameter int unsigned HCRED_W = 8,
  parameter int unsigned DCRED_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               empty_i,
  input  logic [DCRED_W-1:0] dcred_need_i,
  input  logic               consume_i,
  input  logic               upd_i,
  input  logic [HCRED_W-1:0] upd_hdr_i,
  input  logic [DCRED_W-1:0] upd_data_i,
  output logic               eligible_c_o
);

  logic [HCRED_W-1:0] hcred_q, hcred_d;
  logic [DCRED_W-1:0] dcred_q, dcred_d;

  // Consume and return may hit the same VC in one cycle; both are applied.
  always_comb begin
    logic [31:0] h_base, h_ret, d_base, d_ret;
    h_base  = 32'(hcred_q) - (consume_i ? 32'd1 : 32'd0);
    h_ret   = upd_i ? 32'(upd_hdr_i) : 32'd0;
    d_base  = 32'(dcred_q) - (consume_i ? 32'(dcred_need_i) : 32'd0);
    d_ret   = upd_i ? 32'(upd_data_i) : 32'd0;
    hcred_d = HCRED_W'(cred_sat_add(h_base, h_ret, HCRED_W));
    dcred_d = DCRED_W'(cred_sat_add(d_base, d_ret, DCRED_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcred_q <= '0;
      dcred_q <= '0;
    end else begin
      hcred_q <= hcred_d;
      dcred_q <= dcred_d;
    end
  end

  // Registered credits only: a return is usable the cycle after it arrives.
  assign eligible_c_o = !empty_i && (hcred_q != '0) && (dcred_q >= dcred_need_i);

endmodule

// File: rtl/pcie_tx_credit_sched.sv
// Credit-aware weighted round-robin scheduler between per-VC TX FIFOs and the DLL framer.
//   vc_empty/vc_data/vc_dcred_need : show-ahead FIFO heads; rd_en pops the granted VC
//   cfg_weight : consecutive grants per turn (0 behaves as 1)
//   fc_upd_*   : credit returns from the link partner
//   tlp_o/tlp_vc_o/tlp_valid_o/tlp_ready_i : registered output under valid/ready
module pcie_tx_credit_sched
  import pcie_tx_pkg::*;
#(
  parameter  int unsigned NUM_VC   = 2,
  parameter  int unsigned DATA_W   = 224,
  parameter  int unsigned HCRED_W  = 8,
  parameter  int unsigned DCRED_W  = 12,
  parameter  int unsigned WEIGHT_W = 4,
  localparam int unsigned VC_IDX_W = vc_idx_w(NUM_VC)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_VC-1:0]                vc_empty,
  input  logic [NUM_VC-1:0][DATA_W-1:0]    vc_data,
  input  logic [NUM_VC-1:0][DCRED_W-1:0]   vc_dcred_need,
  output logic [NUM_VC-1:0]                rd_en,
  input  logic [NUM_VC-1:0][WEIGHT_W-1:0]  cfg_weight,
  input  logic                             fc_upd_valid,
  input  logic [VC_IDX_W-1:0]              fc_upd_vc,
  input  logic [HCRED_W-1:0]               fc_upd_hdr,
  input  logic [DCRED_W-1:0]               fc_upd_data,
  output logic [DATA_W-1:0]                tlp_o,
  output logic [VC_IDX_W-1:0]              tlp_vc_o,
  output logic                             tlp_valid_o,
  input  logic                             tlp_ready_i
);

  localparam int unsigned IDXP_W = VC_IDX_W + 1;

  sched_state_e          state_q, state_d;
  logic [VC_IDX_W-1:0]   ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]   wcnt_q, wcnt_d;
  logic [DATA_W-1:0]     tlp_q, tlp_d;
  logic [VC_IDX_W-1:0]   tlp_vc_q, tlp_vc_d;
  logic [NUM_VC-1:0]     elig_c;
  logic                  grant_c;
  logic [VC_IDX_W-1:0]   gnt_vc_c;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic upd_c;
    assign upd_c = fc_upd_valid && (fc_upd_vc == VC_IDX_W'(v));

    pcie_fc_credit_ctr #(
      .HCRED_W (HCRED_W),
      .DCRED_W (DCRED_W)
    ) u_ctr (
      .clk          (clk),
      .rst_n        (rst_n),
      .empty_i      (vc_empty[v]),
      .dcred_need_i (vc_dcred_need[v]),
      .consume_i    (rd_en[v]),
      .upd_i        (upd_c),
      .upd_hdr_i    (fc_upd_hdr),
      .upd_data_i   (fc_upd_data),
      .eligible_c_o (elig_c[v])
    );
  end

  // WRR pick, FSM next state and output-register next values.
  always_comb begin
    logic                slot;
    logic                keep;
    logic [WEIGHT_W-1:0] w_eff;
    logic [IDXP_W-1:0]   cand;

    grant_c  = 1'b0;
    gnt_vc_c = ptr_q;
    keep     = 1'b0;
    cand     = '0;
    state_d  = state_q;
    ptr_d    = ptr_q;
    wcnt_d   = wcnt_q;
    tlp_d    = tlp_q;
    tlp_vc_d = tlp_vc_q;

    slot  = (state_q == IDLE) || tlp_ready_i;
    w_eff = (cfg_weight[ptr_q] == '0) ? WEIGHT_W'(1) : cfg_weight[ptr_q];

    if (slot) begin
      // wcnt==0 only out of reset: forces a scan so VC0 is considered first.
      if (elig_c[ptr_q] && (wcnt_q != '0) && (wcnt_q < w_eff)) begin
        grant_c = 1'b1;
        keep    = 1'b1;
      end else begin
        // k==NUM_VC revisits ptr itself, starting it a fresh turn.
        for (int unsigned k = 1; k <= NUM_VC; k++) begin
          cand = IDXP_W'(ptr_q) + IDXP_W'(k);
          if (cand >= IDXP_W'(NUM_VC)) cand = cand - IDXP_W'(NUM_VC);
          if (!grant_c && elig_c[cand[VC_IDX_W-1:0]]) begin
            grant_c  = 1'b1;
            gnt_vc_c = cand[VC_IDX_W-1:0];
          end
        end
      end
    end

    if (grant_c) begin
      ptr_d    = gnt_vc_c;
      wcnt_d   = keep ? (wcnt_q + WEIGHT_W'(1)) : WEIGHT_W'(1);
      tlp_d    = vc_data[gnt_vc_c];
      tlp_vc_d = gnt_vc_c;
    end

    case (state_q)
      IDLE:    if (grant_c) state_d = HOLD;
      HOLD:    if (tlp_ready_i && !grant_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= VC_IDX_W'(NUM_VC - 1);
      wcnt_q   <= '0;
      tlp_q    <= '0;
      tlp_vc_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wcnt_q   <= wcnt_d;
      tlp_q    <= tlp_d;
      tlp_vc_q <= tlp_vc_d;
    end
  end

  assign rd_en       = grant_c ? (NUM_VC'(1) << gnt_vc_c) : '0;
  assign tlp_o       = tlp_q;
  assign tlp_vc_o    = tlp_vc_q;
  assign tlp_valid_o = (state_q == HOLD);

endmodule

// File: tb/tb_pcie_tx_credit_sched.sv
// Self-checking bench for pcie_tx_credit_sched: bench-side FIFOs, hand-derived grant order
// in an expected-TLP queue, compared whenever the framer side accepts a TLP.
module tb_pcie_tx_credit_sched;

  localparam int unsigned NUM_VC   = 2;
  localparam int unsigned DATA_W   = 224;
  localparam int unsigned HCRED_W  = 8;
  localparam int unsigned DCRED_W  = 12;
  localparam int unsigned WEIGHT_W = 4;
  localparam int unsigned VC_IDX_W = 1;

  logic                            clk;
  logic                            rst_n;
  logic [NUM_VC-1:0]               vc_empty;
  logic [NUM_VC-1:0][DATA_W-1:0]   vc_data;
  logic [NUM_VC-1:0][DCRED_W-1:0]  vc_dcred_need;
  logic [NUM_VC-1:0]               rd_en;
  logic [NUM_VC-1:0][WEIGHT_W-1:0] cfg_weight;
  logic                            fc_upd_valid;
  logic [VC_IDX_W-1:0]             fc_upd_vc;
  logic [HCRED_W-1:0]              fc_upd_hdr;
  logic [DCRED_W-1:0]              fc_upd_data;
  logic [DATA_W-1:0]               tlp_o;
  logic [VC_IDX_W-1:0]             tlp_vc_o;
  logic                            tlp_valid_o;
  logic                            tlp_ready_i;

  pcie_tx_credit_sched #(
    .NUM_VC   (NUM_VC),
    .DATA_W   (DATA_W),
    .HCRED_W  (HCRED_W),
    .DCRED_W  (DCRED_W),
    .WEIGHT_W (WEIGHT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vc_empty      (vc_empty),
    .vc_data       (vc_data),
    .vc_dcred_need (vc_dcred_need),
    .rd_en         (rd_en),
    .cfg_weight    (cfg_weight),
    .fc_upd_valid  (fc_upd_valid),
    .fc_upd_vc     (fc_upd_vc),
    .fc_upd_hdr    (fc_upd_hdr),
    .fc_upd_data   (fc_upd_data),
    .tlp_o         (tlp_o),
    .tlp_vc_o      (tlp_vc_o),
    .tlp_valid_o   (tlp_valid_o),
    .tlp_ready_i   (tlp_ready_i)
  );

  typedef struct {
    logic [VC_IDX_W-1:0] vc;
    logic [DATA_W-1:0]   data;
  } exp_t;

  exp_t               exp_q[$];
  logic [DATA_W-1:0]  fifo_mem [NUM_VC][64];
  logic [DCRED_W-1:0] need_mem [NUM_VC][64];
  int                 head   [NUM_VC];
  int                 tail   [NUM_VC];
  int                 exp_rd [NUM_VC];
  logic [NUM_VC-1:0]  gate;
  logic [NUM_VC-1:0]  pop_mask;
  int                 n_checks = 0;
  int                 n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Show-ahead FIFO model; gate hides a VC's contents while credits are being loaded.
  for (genvar v = 0; v < NUM_VC; v++) begin : g_fifo
    assign vc_data[v]       = fifo_mem[v][6'(head[v])];
    assign vc_dcred_need[v] = need_mem[v][6'(head[v])];
    assign vc_empty[v]      = gate[v] || (head[v] == tail[v]);
  end

  always @(negedge clk) pop_mask <= rd_en;

  always @(posedge clk or negedge rst_n) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (!rst_n)           head[v] <= tail[v];
      else if (pop_mask[v]) head[v] <= head[v] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dcred_of(input int v);
    return (v == 0) ? 32'(dut.g_vc[0].u_ctr.dcred_q) : 32'(dut.g_vc[1].u_ctr.dcred_q);
  endfunction

  function automatic logic [31:0] hcred_of(input int v);
    return (v == 0) ? 32'(dut.g_vc[0].u_ctr.hcred_q) : 32'(dut.g_vc[1].u_ctr.hcred_q);
  endfunction

  // Output-side monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rd_en != '0) begin
        check_eq("rd_en_empty", 256'(rd_en & vc_empty), 256'(0));
        check_eq("rd_en_stall", 256'(tlp_valid_o & ~tlp_ready_i), 256'(0));
      end
      if (tlp_valid_o && tlp_ready_i) begin
        if (exp_q.size() == 0) begin
          check_eq("tlp_unexpected", 256'(exp_q.size()), 256'(1));
        end else begin
          e = exp_q.pop_front();
          check_eq("tlp_vc", 256'(tlp_vc_o), 256'(e.vc));
          check_eq("tlp_data", 256'(tlp_o), 256'(e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fc(input int v, input int h, input int d);
    fc_upd_valid = 1'b1;
    fc_upd_vc    = VC_IDX_W'(v);
    fc_upd_hdr   = HCRED_W'(h);
    fc_upd_data  = DCRED_W'(d);
    tick();
    fc_upd_valid = 1'b0;
    fc_upd_hdr   = '0;
    fc_upd_data  = '0;
  endtask

  task automatic push(input int v, input int need);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < int'(DATA_W / 32); i++) d[i*32 +: 32] = $urandom();
    fifo_mem[v][6'(tail[v])] = d;
    need_mem[v][6'(tail[v])] = DCRED_W'(need);
    tail[v]++;
  endtask

  task automatic expect_next(input int v);
    exp_t e;
    e.vc   = VC_IDX_W'(v);
    e.data = fifo_mem[v][6'(exp_rd[v])];
    exp_q.push_back(e);
    exp_rd[v]++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    for (int v = 0; v < NUM_VC; v++) exp_rd[v] = tail[v];
    tick();
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq("drain", 256'(exp_q.size()), 256'(0));
  endtask

  initial begin
    logic [DATA_W-1:0] e1, e2;
    int i1;
    rst_n         = 1'b0;
    gate          = '0;
    cfg_weight[0] = WEIGHT_W'(2);
    cfg_weight[1] = WEIGHT_W'(1);
    fc_upd_valid  = 1'b0;
    fc_upd_vc     = '0;
    fc_upd_hdr    = '0;
    fc_upd_data   = '0;
    tlp_ready_i   = 1'b1;
    tick();
    tick();
    check_eq("rst_valid", 256'(tlp_valid_o), 256'(0));
    check_eq("rst_tlp", 256'(tlp_o), 256'(0));
    check_eq("rst_tlp_vc", 256'(tlp_vc_o), 256'(0));
    check_eq("rst_rd_en", 256'(rd_en), 256'(0));
    check_eq("rst_hcred0", 256'(hcred_of(0)), 256'(0));
    check_eq("rst_dcred1", 256'(dcred_of(1)), 256'(0));
    rst_n = 1'b1;
    tick();

    // No credits: data present but nothing may issue.
    for (int k = 0; k < 5; k++) begin
      push(0, 2);
      push(1, 2);
    end
    for (int c = 0; c < 20; c++) begin
      #1;
      check_eq("nocred_rd_en", 256'(rd_en), 256'(0));
      check_eq("nocred_valid", 256'(tlp_valid_o), 256'(0));
      tick();
    end

    // Weights {2,1}, 4 header credits each: 0,0,1,0,0,1 then VC1 alone.
    gate = '1;
    fc(0, 4, 1000);
    fc(1, 4, 1000);
    expect_next(0); expect_next(0); expect_next(1); expect_next(0);
    expect_next(0); expect_next(1); expect_next(1); expect_next(1);
    gate = '0;
    wait_drain(40);
    tick(); tick(); tick();
    check_eq("wrr_done_rd_en", 256'(rd_en), 256'(0));
    check_eq("wrr_done_valid", 256'(tlp_valid_o), 256'(0));
    check_eq("wrr_hcred0", 256'(hcred_of(0)), 256'(0));
    check_eq("wrr_hcred1", 256'(hcred_of(1)), 256'(0));
    check_eq("wrr_dcred0", 256'(dcred_of(0)), 256'(992));
    check_eq("wrr_dcred1", 256'(dcred_of(1)), 256'(992));

    // VC0 short on data credits is skipped until a return tops it up.
    do_reset();
    gate = '1;
    fc(0, 4, 10);
    fc(1, 4, 100);
    push(0, 16);
    push(1, 1);
    push(1, 1);
    expect_next(1);
    expect_next(1);
    gate = '0;
    wait_drain(20);
    tick(); tick();
    check_eq("vc0_skipped", 256'(rd_en), 256'(0));
    check_eq("vc0_hcred_kept", 256'(hcred_of(0)), 256'(4));
    expect_next(0);
    fc_upd_valid = 1'b1;
    fc_upd_vc    = VC_IDX_W'(0);
    fc_upd_hdr   = '0;
    fc_upd_data  = DCRED_W'(6);
    #1;
    check_eq("fc_not_yet_usable", 256'(rd_en), 256'(0));
    tick();
    fc_upd_valid = 1'b0;
    fc_upd_data  = '0;
    #1;
    check_eq("vc0_after_fc", 256'(rd_en), 256'(1));
    wait_drain(10);
    check_eq("vc0_dcred_spent", 256'(dcred_of(0)), 256'(0));

    // Backpressure: held TLP stays stable, next grant lands with no bubble.
    tick(); tick();
    tlp_ready_i = 1'b0;
    i1 = tail[1];
    push(1, 1);
    push(1, 1);
    e1 = fifo_mem[1][6'(i1)];
    e2 = fifo_mem[1][6'(i1 + 1)];
    expect_next(1);
    expect_next(1);
    tick();
    for (int c = 0; c < 5; c++) begin
      check_eq("stall_data", 256'(tlp_o), 256'(e1));
      check_eq("stall_valid", 256'(tlp_valid_o), 256'(1));
      check_eq("stall_rd_en", 256'(rd_en), 256'(0));
      tick();
    end
    tlp_ready_i = 1'b1;
    #1;
    check_eq("ready_rise_grant", 256'(rd_en), 256'(2));
    tick();
    check_eq("no_bubble_data", 256'(tlp_o), 256'(e2));
    check_eq("no_bubble_valid", 256'(tlp_valid_o), 256'(1));
    wait_drain(10);

    // Grant and return on the same VC in the same cycle: 10 - 3 + 5.
    do_reset();
    fc(1, 2, 10);
    push(1, 3);
    expect_next(1);
    fc_upd_valid = 1'b1;
    fc_upd_vc    = VC_IDX_W'(1);
    fc_upd_hdr   = '0;
    fc_upd_data  = DCRED_W'(5);
    #1;
    check_eq("same_cycle_grant", 256'(rd_en), 256'(2));
    tick();
    fc_upd_valid = 1'b0;
    fc_upd_data  = '0;
    check_eq("same_cycle_dcred", 256'(dcred_of(1)), 256'(12));
    check_eq("same_cycle_hcred", 256'(hcred_of(1)), 256'(1));
    wait_drain(10);

    // Saturation at all-ones.
    do_reset();
    fc(0, 250, 4090);
    check_eq("pre_sat_dcred", 256'(dcred_of(0)), 256'(4090));
    fc(0, 10, 100);
    check_eq("sat_dcred", 256'(dcred_of(0)), 256'(4095));
    check_eq("sat_hcred", 256'(hcred_of(0)), 256'(255));

    // Asynchronous reset with a TLP held: dropped, credits cleared.
    do_reset();
    tlp_ready_i = 1'b0;
    fc(1, 3, 20);
    fc(0, 1, 10);
    push(0, 2);
    tick();
    check_eq("held_valid", 256'(tlp_valid_o), 256'(1));
    check_eq("held_dcred0", 256'(dcred_of(0)), 256'(8));
    check_eq("held_hcred1", 256'(hcred_of(1)), 256'(3));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 256'(tlp_valid_o), 256'(0));
    check_eq("async_rst_tlp", 256'(tlp_o), 256'(0));
    check_eq("async_rst_dcred0", 256'(dcred_of(0)), 256'(0));
    check_eq("async_rst_hcred1", 256'(hcred_of(1)), 256'(0));
    check_eq("async_rst_dcred1", 256'(dcred_of(1)), 256'(0));
    tick();
    rst_n = 1'b1;
    tlp_ready_i = 1'b1;
    tick();
    tick();
    check_eq("post_rst_rd_en", 256'(rd_en), 256'(0));
    check_eq("post_rst_valid", 256'(tlp_valid_o), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
